// File: rtl/ysyx_idu_pipe.sv
// ysyx_idu_pipe -- pipelined RV32I decode stage between IFU and EXU.
//
// Accepts {inst, pc} beats over a valid/ready handshake. Each instruction is
// decoded combinationally: format, register indices, immediate and control
// flags. The result is stored in a BUF_DEPTH-entry output queue. The head
// entry is presented to the EXU with one cycle of registered latency.
//
// Parameters:
//   XLEN      - width of out_imm; the immediate is sign-extended from inst[31]
//               (XLEN >= 32)
//   PC_W      - width of in_pc / out_pc
//   BUF_DEPTH - number of queue entries (>= 1, need not be a power of two)
//
// Ports:
//   clk, rst_n          - clock; synchronous active-low reset
//   flush               - drops all queued entries and this cycle's input beat
//   in_valid/in_ready   - IFU handshake; in_ready depends only on the
//                         registered occupancy count
//   in_inst, in_pc      - instruction word and its PC
//   out_valid/out_ready - EXU handshake for the head entry
//   out_pc .. out_ebreak- decoded fields of the head entry; all read 0 while
//                         the queue is empty
//   out_illegal         - illegal-instruction flag; present only when
//                         YSYX_IDU_ILLEGAL_TRAP_EN is defined
//
// Optional feature macro: YSYX_IDU_ILLEGAL_TRAP_EN
//   When defined, the stage flags unknown opcodes, non-32-bit encodings and
//   R-type instructions whose funct7 is not 0000000/0100000. A flagged entry
//   is still queued, with rd write-enable forced low.
module ysyx_idu_pipe #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_type,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic            out_ebreak
`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
  ,
  output logic            out_illegal
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // One-hot format encoding {J,U,B,S,I,R}
  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      typ;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic            ebreak;
`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t             dec_s;
  entry_t             head_s;
  logic [31:0]        imm32_s;
  logic               push_s;
  logic               pop_s;
  entry_t             mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  // Advance a queue pointer, wrapping from BUF_DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Combinational decode of the incoming instruction word
  always_comb begin
    dec_s          = '0;
    imm32_s        = 32'h0;
    dec_s.pc       = in_pc;
    dec_s.opcode   = in_inst[6:0];
    dec_s.funct3   = in_inst[14:12];
    dec_s.funct7b5 = in_inst[30];
    dec_s.ebreak   = (in_inst == 32'h0010_0073);

    case (in_inst[6:0])
      7'b0110011:                                     dec_s.typ = T_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_s.typ = T_I;
      7'b0100011:                                     dec_s.typ = T_S;
      7'b1100011:                                     dec_s.typ = T_B;
      7'b0110111, 7'b0010111:                         dec_s.typ = T_U;
      7'b1101111:                                     dec_s.typ = T_J;
      default:                                        dec_s.typ = 6'b000000;
    endcase

    case (dec_s.typ)
      T_I:     imm32_s = {{20{in_inst[31]}}, in_inst[31:20]};
      T_S:     imm32_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      T_B:     imm32_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      T_U:     imm32_s = {in_inst[31:12], 12'h000};
      T_J:     imm32_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      default: imm32_s = 32'h0;
    endcase
    dec_s.imm = XLEN'($signed(imm32_s));

    // U/J carry no source registers; I/U/J carry no rs2; S/B carry no rd
    if ((dec_s.typ == T_U) || (dec_s.typ == T_J)) begin
      dec_s.rs1 = 5'd0;
    end else begin
      dec_s.rs1 = in_inst[19:15];
    end
    if ((dec_s.typ == T_I) || (dec_s.typ == T_U) || (dec_s.typ == T_J)) begin
      dec_s.rs2 = 5'd0;
    end else begin
      dec_s.rs2 = in_inst[24:20];
    end
    if ((dec_s.typ == T_S) || (dec_s.typ == T_B)) begin
      dec_s.rd = 5'd0;
    end else begin
      dec_s.rd = in_inst[11:7];
    end

`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
    dec_s.illegal = (dec_s.typ == 6'b000000) || (in_inst[1:0] != 2'b11) ||
                    ((dec_s.typ == T_R) && (in_inst[31:25] != 7'b0000000) &&
                     (in_inst[31:25] != 7'b0100000));
    dec_s.rd_we   = ((dec_s.typ & 6'b110011) != 6'b000000) &&
                    (dec_s.rd != 5'd0) && !dec_s.illegal;
`else
    dec_s.rd_we   = ((dec_s.typ & 6'b110011) != 6'b000000) &&
                    (dec_s.rd != 5'd0);
`endif
  end

  assign in_ready  = (count_r != CNT_W'(BUF_DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;

  // Occupancy count and read/write pointers
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are masked on the outputs while empty, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= dec_s;
    end
  end

  // Head entry, forced to zero while the queue is empty
  always_comb begin
    head_s = '0;
    if (out_valid) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_pc       = head_s.pc;
  assign out_type     = head_s.typ;
  assign out_opcode   = head_s.opcode;
  assign out_funct3   = head_s.funct3;
  assign out_funct7b5 = head_s.funct7b5;
  assign out_rs1      = head_s.rs1;
  assign out_rs2      = head_s.rs2;
  assign out_rd       = head_s.rd;
  assign out_rd_we    = head_s.rd_we;
  assign out_imm      = head_s.imm;
  assign out_ebreak   = head_s.ebreak;
`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
  assign out_illegal  = head_s.illegal;
`endif

endmodule

// File: tb/tb_ysyx_idu_pipe.sv
// tb_ysyx_idu_pipe -- scoreboard bench for ysyx_idu_pipe (BUF_DEPTH=2).
// The driver pushes hand-computed expected entries when a beat is accepted;
// the monitor pops and compares whenever the DUT hands off its head entry.
module tb_ysyx_idu_pipe;

`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  typ;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  out_type;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_imm;
  logic        out_ebreak;
  logic        illegal_obs;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_cur;
  exp_t sb[$];

  ysyx_idu_pipe #(.XLEN(32), .PC_W(32), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_type(out_type), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_imm(out_imm),
    .out_ebreak(out_ebreak)
`ifdef YSYX_IDU_ILLEGAL_TRAP_EN
    , .out_illegal(illegal_obs)
`endif
  );

`ifndef YSYX_IDU_ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected entry: opcode/funct fields are plain bit slices of the word,
  // everything else is hand-computed by the caller.
  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [5:0] typ, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic we, input logic [31:0] imm,
                              input logic eb, input logic ill);
    exp_t e;
    e.pc = pc; e.typ = typ; e.opcode = inst[6:0]; e.funct3 = inst[14:12];
    e.funct7b5 = inst[30]; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rd_we = we; e.imm = imm; e.ebreak = eb; e.illegal = ill;
    return e;
  endfunction

  // Scoreboard: pop/compare on handoff, then record any accepted beat
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got pc %0h expected no entry", out_pc);
        end else begin
          e = sb.pop_front();
          check("pc", {32'h0, out_pc}, {32'h0, e.pc});
          check("type", {58'h0, out_type}, {58'h0, e.typ});
          check("regs", {49'h0, out_rs1, out_rs2, out_rd}, {49'h0, e.rs1, e.rs2, e.rd});
          check("imm", {32'h0, out_imm}, {32'h0, e.imm});
          check("misc", {51'h0, out_opcode, out_funct3, out_funct7b5, out_rd_we, out_ebreak},
                {51'h0, e.opcode, e.funct3, e.funct7b5, e.rd_we, e.ebreak});
          if (ILL_EN) check("illegal", {63'h0, illegal_obs}, {63'h0, e.illegal});
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  // Offer one beat and hold it until accepted (bounded)
  task automatic send(input logic [31:0] inst, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; in_inst = inst; in_pc = e.pc; exp_cur = e;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for pc %0h", e.pc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_fields", {26'h0, out_pc, out_type}, 64'h0);
    @(posedge clk); #1;

    // Decode stream, EXU always ready
    out_ready = 1'b1;
    send(32'h0050_0093, mk(32'h0050_0093, 32'h8000_0000, T_I, 5'd0, 5'd0, 5'd1, 1'b1, 32'h5, 1'b0, 1'b0));
    @(negedge clk);
    check("latency", {63'h0, out_valid}, 64'h1);
    @(posedge clk); #1;
    send(32'hFE20_AE23, mk(32'hFE20_AE23, 32'h8000_0004, T_S, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0));
    send(32'hFF9F_F0EF, mk(32'hFF9F_F0EF, 32'h8000_0008, T_J, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0));
    send(32'h0010_0073, mk(32'h0010_0073, 32'h8000_000C, T_I, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1, 1'b1, 1'b0));
    send(32'h0020_81B3, mk(32'h0020_81B3, 32'h8000_0010, T_R, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0));
    send(32'h4073_02B3, mk(32'h4073_02B3, 32'h8000_0014, T_R, 5'd6, 5'd7, 5'd5, 1'b1, 32'h0, 1'b0, 1'b0));
    send(32'hFE20_8EE3, mk(32'hFE20_8EE3, 32'h8000_0018, T_B, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0));
    send(32'h1234_5537, mk(32'h1234_5537, 32'h8000_001C, T_U, 5'd0, 5'd0, 5'd10, 1'b1, 32'h1234_5000, 1'b0, 1'b0));
    send(32'h0041_2283, mk(32'h0041_2283, 32'h8000_0020, T_I, 5'd2, 5'd0, 5'd5, 1'b1, 32'h4, 1'b0, 1'b0));
    send(32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'h8000_0024, 6'b000000, 5'd31, 5'd31, 5'd31, 1'b0, 32'h0, 1'b0, 1'b1));
    send(32'h0220_81B3, mk(32'h0220_81B3, 32'h8000_0028, T_R, 5'd1, 5'd2, 5'd3, !ILL_EN, 32'h0, 1'b0, ILL_EN));
    cycles(4);
    check("drain_stream", {32'h0, 32'(sb.size())}, 64'h0);

    // Backpressure: queue of two fills, third beat waits, order preserved
    out_ready = 1'b0;
    send(32'h0050_0093, mk(32'h0050_0093, 32'h9000_0000, T_I, 5'd0, 5'd0, 5'd1, 1'b1, 32'h5, 1'b0, 1'b0));
    send(32'h0020_81B3, mk(32'h0020_81B3, 32'h9000_0004, T_R, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0));
    @(negedge clk);
    check("full_in_ready", {63'h0, in_ready}, 64'h0);
    check("full_head_pc", {32'h0, out_pc}, 64'h9000_0000);
    fork
      send(32'h1234_5537, mk(32'h1234_5537, 32'h9000_0008, T_U, 5'd0, 5'd0, 5'd10, 1'b1, 32'h1234_5000, 1'b0, 1'b0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_stable", {32'h0, out_pc, 26'h0, out_type}, {32'h9000_0000, 26'h0, T_I});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    cycles(4);
    check("drain_bp", {32'h0, 32'(sb.size())}, 64'h0);
    check("empty_bp", {63'h0, out_valid}, 64'h0);

    // Flush a full queue together with an offered beat
    out_ready = 1'b0;
    send(32'h0041_2283, mk(32'h0041_2283, 32'hA000_0000, T_I, 5'd2, 5'd0, 5'd5, 1'b1, 32'h4, 1'b0, 1'b0));
    send(32'hFE20_AE23, mk(32'hFE20_AE23, 32'hA000_0004, T_S, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0));
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'hDEAD_0000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'h0, out_valid}, 64'h0);
    check("flush_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFF9F_F0EF, mk(32'hFF9F_F0EF, 32'hA000_0008, T_J, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0));
    cycles(3);
    check("drain_flush", {32'h0, 32'(sb.size())}, 64'h0);

    // Reset in the middle of traffic
    out_ready = 1'b0;
    send(32'h0010_0073, mk(32'h0010_0073, 32'hB000_0000, T_I, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1, 1'b1, 1'b0));
    in_valid = 1'b1; in_inst = 32'h0020_81B3; in_pc = 32'hB000_0004; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
    check("midrst_fields", {32'h0, out_pc}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
